// File: rtl/rca_pipe_add.sv
// Pipelined ripple-carry adder/subtractor: one BLK-wide ripple block per stage,
// registered carry between stages, valid/ready flow control with global stall.
module rca_pipe_add #(
  parameter int WIDTH = 80,
  parameter int BLK   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int BLK_SAFE = (BLK < 1) ? 1 : BLK;
  localparam int NBLK     = (WIDTH / BLK_SAFE < 1) ? 1 : WIDTH / BLK_SAFE;

  if ((BLK < 1) || ((WIDTH % BLK_SAFE) != 0) || (WIDTH < BLK_SAFE)) begin : g_param_check
    $error("rca_pipe_add: WIDTH must be a positive multiple of BLK and BLK must be >= 1");
  end

  // Index 0 is the operand capture register; index k+1 is the output of ripple stage k.
  logic             v_reg [0:NBLK];
  logic             c_reg [0:NBLK];
  logic [WIDTH-1:0] a_reg [0:NBLK-1];
  logic [WIDTH-1:0] b_reg [0:NBLK-1];
  logic [WIDTH-1:0] s_reg [1:NBLK];
  logic             ovf_reg;
  logic             en;

  // Whole pipeline advances together; bubbles are held, not collapsed.
  assign en       = !v_reg[NBLK] || out_ready;
  assign in_ready = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_reg[0] <= 1'b0;
      c_reg[0] <= 1'b0;
      a_reg[0] <= '0;
      b_reg[0] <= '0;
    end else if (en) begin
      v_reg[0] <= in_valid;
      c_reg[0] <= sub | cin;
      a_reg[0] <= a;
      b_reg[0] <= b ^ {WIDTH{sub}};
    end
  end

  for (genvar gi = 0; gi < NBLK; gi++) begin : g_stage
    logic [BLK_SAFE:0]   blk_sum;
    logic [WIDTH-1:0]    blk_ext;
    logic [WIDTH-1:0]    s_prev;
    logic [WIDTH-1:0]    s_new;

    assign blk_sum = {1'b0, a_reg[gi][BLK_SAFE-1:0]}
                   + {1'b0, b_reg[gi][BLK_SAFE-1:0]}
                   + {{BLK_SAFE{1'b0}}, c_reg[gi]};
    assign blk_ext = WIDTH'(blk_sum[BLK_SAFE-1:0]);

    if (gi == 0) begin : g_first
      assign s_prev = '0;
    end else begin : g_next
      assign s_prev = s_reg[gi];
    end

    // New block enters at the top and earlier blocks shift down, so after the
    // final stage every block sits at its natural position.
    assign s_new = (s_prev >> BLK_SAFE) | (blk_ext << (WIDTH - BLK_SAFE));

    always_ff @(posedge clk) begin
      if (rst) begin
        v_reg[gi+1] <= 1'b0;
        c_reg[gi+1] <= 1'b0;
        s_reg[gi+1] <= '0;
      end else if (en) begin
        v_reg[gi+1] <= v_reg[gi];
        c_reg[gi+1] <= blk_sum[BLK_SAFE];
        s_reg[gi+1] <= s_new;
      end
    end

    if (gi < NBLK - 1) begin : g_pass
      // Pending operand blocks shift down so the next stage always reads bits [BLK-1:0].
      always_ff @(posedge clk) begin
        if (rst) begin
          a_reg[gi+1] <= '0;
          b_reg[gi+1] <= '0;
        end else if (en) begin
          a_reg[gi+1] <= a_reg[gi] >> BLK_SAFE;
          b_reg[gi+1] <= b_reg[gi] >> BLK_SAFE;
        end
      end
    end else begin : g_last
      logic carry_into_msb;
      assign carry_into_msb = a_reg[gi][BLK_SAFE-1] ^ b_reg[gi][BLK_SAFE-1] ^ blk_sum[BLK_SAFE-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_reg <= 1'b0;
        end else if (en) begin
          ovf_reg <= carry_into_msb ^ blk_sum[BLK_SAFE];
        end
      end
    end
  end

  assign out_valid = v_reg[NBLK];
  assign s         = s_reg[NBLK];
  assign cout      = c_reg[NBLK];
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_rca_pipe_add.sv
// Directed bench for rca_pipe_add at WIDTH=80, BLK=16 (latency 5).
module tb_rca_pipe_add;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [79:0] a;
  logic [79:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [79:0] s;
  logic        cout;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  rca_pipe_add #(.WIDTH(80), .BLK(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (s !== 80'h0) begin bad++; $display("FAIL reset_s got=%h want=0", s); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", cout); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    tick();
  endtask

  task automatic test_vectors();
    logic [79:0] va [7];
    logic [79:0] vb [7];
    logic [79:0] vs [7];
    logic        vcin [7];
    logic        vsub [7];
    logic        vco [7];
    logic        vov [7];
    va[0] = 80'h1;                    vb[0] = 80'h1;                    vcin[0] = 0; vsub[0] = 0;
    vs[0] = 80'h2;                    vco[0] = 0; vov[0] = 0;
    va[1] = 80'hFFFFFFFFFFFFFFFFFFFF; vb[1] = 80'h1;                    vcin[1] = 0; vsub[1] = 0;
    vs[1] = 80'h0;                    vco[1] = 1; vov[1] = 0;
    va[2] = 80'hABCDEF1234567890FFFF; vb[2] = 80'h11111111111111111111; vcin[2] = 1; vsub[2] = 0;
    vs[2] = 80'hBCDF0023456789A21111; vco[2] = 0; vov[2] = 0;
    va[3] = 80'h5;                    vb[3] = 80'h7;                    vcin[3] = 1; vsub[3] = 1;
    vs[3] = 80'hFFFFFFFFFFFFFFFFFFFE; vco[3] = 0; vov[3] = 0;
    va[4] = 80'h7FFFFFFFFFFFFFFFFFFF; vb[4] = 80'hFFFFFFFFFFFFFFFFFFFF; vcin[4] = 0; vsub[4] = 1;
    vs[4] = 80'h80000000000000000000; vco[4] = 0; vov[4] = 1;
    va[5] = 80'h80000000000000000000; vb[5] = 80'h1;                    vcin[5] = 0; vsub[5] = 1;
    vs[5] = 80'h7FFFFFFFFFFFFFFFFFFF; vco[5] = 1; vov[5] = 1;
    va[6] = 80'h7FFFFFFFFFFFFFFFFFFF; vb[6] = 80'h1;                    vcin[6] = 0; vsub[6] = 0;
    vs[6] = 80'h80000000000000000000; vco[6] = 0; vov[6] = 1;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; a = va[i]; b = vb[i]; cin = vcin[i]; sub = vsub[i];
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL vec%0d_early_valid cycle=%0d got=%b want=0", i, k, out_valid); end
      end
      tick();
      $display("vec%0d: s=%h cout=%b ovf=%b valid=%b", i, s, cout, ovf, out_valid);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL vec%0d_valid got=%b want=1", i, out_valid); end
      total++; if (s !== vs[i]) begin bad++; $display("FAIL vec%0d_s got=%h want=%h", i, s, vs[i]); end
      total++; if (cout !== vco[i]) begin bad++; $display("FAIL vec%0d_cout got=%b want=%b", i, cout, vco[i]); end
      total++; if (ovf !== vov[i]) begin bad++; $display("FAIL vec%0d_ovf got=%b want=%b", i, ovf, vov[i]); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL vec%0d_single_valid got=%b want=0", i, out_valid); end
    end
  endtask

  // Ten back-to-back beats with out_ready held high: accept and retire overlap.
  task automatic test_back_to_back();
    logic        exp_v;
    logic [79:0] exp_s;
    for (int n = -1; n <= 15; n++) begin
      in_valid = (n <= 8); a = 80'((n + 2) * 1000); b = 80'(n + 2); cin = 1'b0; sub = 1'b0;
      out_ready = 1'b1;
      #1;
      if (n >= 0) begin
        exp_v = (n >= 5) && (n <= 14);
        exp_s = 80'(1001 * (n - 4));
        total++; if (out_valid !== exp_v) begin bad++; $display("FAIL b2b_valid win=%0d got=%b want=%b", n, out_valid, exp_v); end
        if (exp_v) begin
          $display("b2b win=%0d: s=%0d", n, s);
          total++; if (s !== exp_s) begin bad++; $display("FAIL b2b_s win=%0d got=%0d want=%0d", n, s, exp_s); end
        end
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Six beats, then out_ready low for the 7th..10th cycles after the first accept.
  task automatic test_backpressure();
    logic        exp_v;
    logic        exp_rdy;
    logic [79:0] exp_s;
    for (int n = -1; n <= 16; n++) begin
      in_valid = (n <= 4); a = 80'(n + 2); b = 80'(n + 2); cin = 1'b0; sub = 1'b0;
      out_ready = !((n >= 6) && (n <= 9));
      #1;
      exp_rdy = !((n >= 6) && (n <= 9));
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL bp_in_ready win=%0d got=%b want=%b", n, in_ready, exp_rdy); end
      if (n >= 0) begin
        exp_v = (n >= 5) && (n <= 14);
        exp_s = (n == 5) ? 80'd2 : (n <= 10) ? 80'd4 : 80'(2 * (n - 8));
        total++; if (out_valid !== exp_v) begin bad++; $display("FAIL bp_valid win=%0d got=%b want=%b", n, out_valid, exp_v); end
        if (exp_v) begin
          $display("bp win=%0d: s=%0d ready=%b", n, s, out_ready);
          total++; if (s !== exp_s) begin bad++; $display("FAIL bp_s win=%0d got=%0d want=%0d", n, s, exp_s); end
        end
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; a = 80'(i * 100); b = 80'(i);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
    total++; if (s !== 80'h0) begin bad++; $display("FAIL rstmid_s got=%h want=0", s); end
    for (int k = 0; k < 6; k++) begin
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_stale win=%0d got=%b want=0", k, out_valid); end
      tick();
    end
    in_valid = 1'b1; a = 80'h3; b = 80'h4;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_early win=%0d got=%b want=0", k, out_valid); end
    end
    tick();
    $display("rstmid: s=%h valid=%b", s, out_valid);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_new_valid got=%b want=1", out_valid); end
    total++; if (s !== 80'h7) begin bad++; $display("FAIL rstmid_new_s got=%h want=7", s); end
    tick();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rca_pipe_add.md
Name: rca_pipe_add

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor. Successor to the fixed 80-bit, 16-bit-block RCA.
- The WIDTH-bit operation is split into NBLK = WIDTH/BLK ripple blocks, with one register stage per block. Carry is registered between stages.
- Valid/ready handshakes on input and output. Throughput is one operation per cycle.
- Used as the wide-add datapath element wherever a long combinational ripple would break timing.

Parameters:
- WIDTH, 80, operand and sum width in bits; must be a multiple of BLK.
- BLK, 16, ripple block width in bits. Also the bits resolved per pipeline stage.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in; ignored when sub=1
- sub  input  1  0: S=A+B+cin; 1: S=A+~B+1 (A-B)
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- s  output  WIDTH  sum/difference
- cout  output  1  raw carry out of bit WIDTH-1; for sub, 1 means no borrow
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (rst=1 at posedge): every stage valid bit cleared; out_valid=0, s=0, cout=0, ovf=0.
  - Applies mid-operation: all in-flight beats are discarded.
  - in_ready=1 in the first cycle after reset deasserts.
- Input acceptance: a beat is accepted when in_valid && in_ready at a posedge.
  - Effective B is b^{WIDTH{sub}}.
  - Effective carry-in is sub ? 1 : cin.
- Stage k (0..NBLK-1) adds block k, bits [k*BLK +: BLK], of A and effective B with the carry from stage k-1.
  - Stage 0 uses the effective carry-in.
  - Each stage registers the sum blocks computed so far, the upper operand blocks still pending, the carry, and a valid bit.
  - Lower result blocks are carried forward in the stage registers (skew-free output).
- Latency: a beat accepted at edge t is presented with out_valid=1 after edge t+NBLK (default: 5 cycles).
- Outputs s/cout/ovf come directly from the final stage register.
- ovf = carry into MSB XOR carry out of MSB, computed in the final stage.
- Flow control: pipeline advance enable en = !out_valid || out_ready, and in_ready = en.
  - When en=0, every stage holds, including bubbles. There is no bubble collapsing.
  - in_ready depends on out_ready combinationally; there is no in_valid to in_ready path.
- Output stability: while out_valid && !out_ready, s/cout/ovf are held unchanged.
- Ordering: results leave strictly in acceptance order. No beat is dropped or duplicated.
- Simultaneous accept and retire in the same cycle is allowed (full throughput).
- Bubbles (in_valid=0 while en=1) propagate as invalid stages. Data in invalid stages is don't-care, but outputs are only qualified by out_valid.
- Elaboration: WIDTH%BLK != 0 or BLK<1 must halt elaboration with an error.

Test Plan:
- WIDTH=80, BLK=16, out_ready=1: a=0x…01, b=0x…01, cin=0, sub=0 -> after 5 cycles out_valid=1 for exactly one cycle, s=0x00000000000000000002, cout=0, ovf=0.
- a=0xFFFFFFFFFFFFFFFFFFFF, b=0x1, cin=0 -> s=0, cout=1, ovf=0. Carry must ripple through all 5 stages.
- a=0xABCDEF1234567890FFFF, b=0x11111111111111111111, cin=1 -> s=0xBCDF0023456789A21111, cout=0.
- sub=1, a=5, b=7, cin=1 -> s=0xFFFFFFFFFFFFFFFFFFFE, cout=0, ovf=0. Then a=0x7FFF…FF, b=0xFFFF…FF (-1), sub=1 -> s=0x8000…00, ovf=1.
- Backpressure:
  - Stimulus: 6 back-to-back beats (a=i, b=i, i=1..6), with out_ready=0 for cycles 7-10 after the first accept.
  - Required: in_ready=0 exactly when out_valid && !out_ready; s and beat order stay stable while stalled; outputs 2,4,6,8,10,12 in order with none lost.
- Reset mid-stream: 3 beats in flight, rst=1 for one cycle -> out_valid=0 for 5 cycles after reset (no stale beats). A new beat then completes with latency 5.
